// File: rtl/alu_pkg.sv
// Shared definitions for the packed-instruction ALU interface: opcodes,
// instruction field layout, result width and the initiator FSM states.
package alu_pkg;

  localparam int OPND_W   = 3;
  localparam int OP_W     = 2;
  localparam int INSTR_W  = 8;
  localparam int RESULT_W = 6;

  localparam int A_LSB  = 0;
  localparam int B_LSB  = 3;
  localparam int OP_LSB = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  function automatic logic is_div_by_zero(input alu_op_e op, input logic [OPND_W-1:0] b);
    return (op == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_golden_calc.sv
// Combinational golden model of the ALU core: operands zero-extended to 8 bits,
// result is the full 8-bit value (callers compare the low RESULT_W bits).
module alu_golden_calc
  import alu_pkg::*;
(
  input  alu_op_e                  i_op,
  input  logic [OPND_W-1:0]        i_a,
  input  logic [OPND_W-1:0]        i_b,
  output logic [INSTR_W-1:0]       o_golden,
  output logic                     o_div_by_zero
);

  logic [INSTR_W-1:0] w_a8;
  logic [INSTR_W-1:0] w_b8;

  assign w_a8          = {{(INSTR_W-OPND_W){1'b0}}, i_a};
  assign w_b8          = {{(INSTR_W-OPND_W){1'b0}}, i_b};
  assign o_div_by_zero = is_div_by_zero(i_op, i_b);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_golden = '0;
    case (i_op)
      OP_ADD: o_golden = w_a8 + w_b8;
      OP_SUB: o_golden = w_a8 - w_b8;
      OP_MUL: o_golden = w_a8 * w_b8;
      OP_DIV: if (!o_div_by_zero) o_golden = w_a8 / w_b8;
      default: o_golden = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_initiator.sv
// Initiator for the packed-instruction ALU: packs requests into instruction bytes,
// pulses the ALU enable, checks the registered result and returns it with statistics.
module alu_cmd_initiator
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [2:0]           req_a,
  input  logic [2:0]           req_b,
  output logic [7:0]           alu_instr,
  output logic                 alu_ena,
  input  logic [7:0]           alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [5:0]           rsp_result,
  output logic [1:0]           rsp_op,
  output logic                 rsp_err,
  output logic                 rsp_mismatch,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int SETTLE_W = 4;

  state_e               r_state;
  state_e               w_next;
  alu_op_e              r_op;
  logic [OPND_W-1:0]    r_a;
  logic [OPND_W-1:0]    r_b;
  logic [SETTLE_W-1:0]  r_settle;
  logic [RESULT_W-1:0]  r_rsp_result;
  alu_op_e              r_rsp_op;
  logic                 r_rsp_err;
  logic                 r_rsp_mismatch;
  logic [CNT_W-1:0]     r_op_count;
  logic [CNT_W-1:0]     r_err_count;

  logic                 w_accept;
  logic                 w_req_dz;
  logic                 w_settle_dec;
  logic                 w_capture;
  logic                 w_consume;
  logic                 w_mismatch;
  logic [INSTR_W-1:0]   w_golden;
  logic                 w_unused_dz;
  logic                 w_unused_golden_hi;

  alu_golden_calc u_golden (
    .i_op          (r_op),
    .i_a           (r_a),
    .i_b           (r_b),
    .o_golden      (w_golden),
    .o_div_by_zero (w_unused_dz)
  );

  assign w_unused_golden_hi = ^w_golden[INSTR_W-1:RESULT_W];
  assign w_req_dz   = is_div_by_zero(alu_op_e'(req_op), req_b);
  assign w_mismatch = (alu_out[RESULT_W-1:0] != w_golden[RESULT_W-1:0]) ||
                      (alu_out[OP_LSB +: OP_W] != r_op);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_settle_dec = 1'b0;
    w_capture    = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          w_accept = 1'b1;
          w_next   = w_req_dz ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (r_settle == '0) begin
          w_capture = 1'b1;
          w_next    = ST_RESP;
        end else begin
          w_settle_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_consume = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op           <= OP_ADD;
      r_a            <= '0;
      r_b            <= '0;
      r_settle       <= '0;
      r_rsp_result   <= '0;
      r_rsp_op       <= OP_ADD;
      r_rsp_err      <= 1'b0;
      r_rsp_mismatch <= 1'b0;
      r_op_count     <= '0;
      r_err_count    <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= alu_op_e'(req_op);
        r_a      <= req_a;
        r_b      <= req_b;
        r_settle <= SETTLE_W'(SETTLE_CYCLES - 1);
        // A rejected divide skips the ALU entirely and answers straight from IDLE.
        if (w_req_dz) begin
          r_rsp_result   <= '0;
          r_rsp_op       <= alu_op_e'(req_op);
          r_rsp_err      <= 1'b1;
          r_rsp_mismatch <= 1'b0;
        end
      end
      if (w_settle_dec) r_settle <= r_settle - 1'b1;
      if (w_capture) begin
        r_rsp_result   <= alu_out[RESULT_W-1:0];
        r_rsp_op       <= r_op;
        r_rsp_err      <= 1'b0;
        r_rsp_mismatch <= w_mismatch;
      end
      if (w_consume) begin
        if (r_op_count != '1) r_op_count <= r_op_count + 1'b1;
        if ((r_rsp_err || r_rsp_mismatch) && (r_err_count != '1))
          r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  // The instruction stays on the bus through WAIT so the ALU's opcode echo remains valid.
  assign alu_instr    = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) ?
                        {r_op, r_b, r_a} : '0;
  assign alu_ena      = (r_state == ST_ISSUE);
  assign req_ready    = (r_state == ST_IDLE) && !rst;
  assign rsp_valid    = (r_state == ST_RESP);
  assign busy         = (r_state != ST_IDLE);
  assign rsp_result   = r_rsp_result;
  assign rsp_op       = r_rsp_op;
  assign rsp_err      = r_rsp_err;
  assign rsp_mismatch = r_rsp_mismatch;
  assign op_count     = r_op_count;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Bench for alu_cmd_initiator: a behavioural ALU core plus an arithmetic reference
// model for results, latency, enable pulses and the saturating counters.
module tb_alu_cmd_initiator;

  localparam int SETTLE  = 1;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [2:0]       req_a = '0;
  logic [2:0]       req_b = '0;
  logic [7:0]       alu_instr;
  logic             alu_ena;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [5:0]       rsp_result;
  logic [1:0]       rsp_op;
  logic             rsp_err;
  logic             rsp_mismatch;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ops  = 0;
  int exp_errs = 0;
  int ena_pulses = 0;
  logic [7:0] last_instr = '0;
  bit force_zero = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_initiator #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_instr(alu_instr),
    .alu_ena(alu_ena), .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .rsp_mismatch(rsp_mismatch), .busy(busy), .op_count(op_count), .err_count(err_count)
  );

  function automatic int ref_value(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * b) % 256;
      default: return (b == 0) ? 0 : a / b;
    endcase
  endfunction

  // Behavioural ALU core: registers {opcode echo, result} one cycle after enable.
  always @(posedge clk) begin
    if (rst) alu_out <= '0;
    else if (alu_ena) begin
      int v;
      v = ref_value(int'(alu_instr[7:6]), int'(alu_instr[2:0]), int'(alu_instr[5:3]));
      alu_out <= {alu_instr[7:6], force_zero ? 6'd0 : 6'(v % 64)};
    end
  end

  always @(negedge clk) begin
    if (alu_ena === 1'b1) begin
      ena_pulses++;
      last_instr = alu_instr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; returns at a negedge with the response consumed.
  task automatic do_op(input int op, input int a, input int b, input bit fz,
                       input int hold, input bit full);
    int lat, g, exp_res, pulses0;
    bit dz, exp_mm;
    dz      = (op == 3) && (b == 0);
    g       = ref_value(op, a, b);
    exp_res = (dz || fz) ? 0 : g % 64;
    exp_mm  = !dz && fz && ((g % 64) != 0);
    force_zero = fz;
    req_valid = 1'b1; req_op = 2'(op); req_a = 3'(a); req_b = 3'(b);
    pulses0 = ena_pulses;
    if (full) begin
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b expected 1", req_ready);
      else n_pass++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, expected 1", rsp_valid, lat);
      return;
    end
    n_pass++;
    n_checks++;
    if (lat != (dz ? 1 : 2 + SETTLE)) $display("FAIL latency: got %0d expected %0d", lat, dz ? 1 : 2 + SETTLE);
    else n_pass++;
    n_checks++;
    if (rsp_result !== 6'(exp_res)) $display("FAIL rsp_result op=%0d a=%0d b=%0d: got %0d expected %0d", op, a, b, rsp_result, exp_res);
    else n_pass++;
    n_checks++;
    if (rsp_err !== dz || rsp_mismatch !== exp_mm || rsp_op !== 2'(op))
      $display("FAIL rsp_flags: err/mm/op got %b/%b/%0d expected %b/%b/%0d", rsp_err, rsp_mismatch, rsp_op, dz, exp_mm, op);
    else n_pass++;
    if (full) begin
      n_checks++;
      if (ena_pulses - pulses0 != (dz ? 0 : 1)) $display("FAIL ena_pulses: got %0d expected %0d", ena_pulses - pulses0, dz ? 0 : 1);
      else n_pass++;
      if (!dz) begin
        n_checks++;
        if (last_instr !== {2'(op), 3'(b), 3'(a)}) $display("FAIL alu_instr: got %h expected %h", last_instr, {2'(op), 3'(b), 3'(a)});
        else n_pass++;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 || rsp_result !== 6'(exp_res) ||
          rsp_mismatch !== exp_mm || rsp_err !== dz || rsp_op !== 2'(op))
        $display("FAIL hold_stable cycle %0d: valid/ready/busy/result %b/%b/%b/%0d expected 1/0/1/%0d", i, rsp_valid, req_ready, busy, rsp_result, exp_res);
      else n_pass++;
    end
    if (exp_ops < CNT_MAX) exp_ops++;
    if ((dz || exp_mm) && exp_errs < CNT_MAX) exp_errs++;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    force_zero = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_instr !== 8'h00) $display("FAIL post_consume: valid/busy/instr %b/%b/%h expected 0/0/00", rsp_valid, busy, alu_instr);
    else n_pass++;
    n_checks++;
    if (op_count !== CNT_W'(exp_ops) || err_count !== CNT_W'(exp_errs))
      $display("FAIL counters: op/err got %0d/%0d expected %0d/%0d", op_count, err_count, exp_ops, exp_errs);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || alu_instr !== 8'h00 || alu_ena !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_result !== 6'd0 || rsp_op !== 2'd0 || rsp_err !== 1'b0 || rsp_mismatch !== 1'b0 ||
        op_count !== '0 || err_count !== '0)
      $display("FAIL reset_state: ready/instr/ena/valid/ops/errs %b/%h/%b/%b/%0d/%0d expected all 0", req_ready, alu_instr, alu_ena, rsp_valid, op_count, err_count);
    else n_pass++;
    rst = 1'b0;
    exp_ops = 0; exp_errs = 0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_op(0, 5, 6, 1'b0, 0, 1'b1);
    do_op(1, 2, 5, 1'b0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_op(2, 7, 7, 1'b0, 0, 1'b1);
    do_op(3, 7, 2, 1'b0, 0, 1'b1);
  endtask

  task automatic test_div_by_zero();
    do_op(3, 3, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_mismatch_hold();
    do_op(0, 1, 1, 1'b1, 5, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_op(int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(7)),
            ($urandom_range(9) == 0), int'($urandom_range(3)), 1'b1);
  endtask

  task automatic test_reset_mid_op();
    req_valid = 1'b1; req_op = 2'd0; req_a = 3'd3; req_b = 3'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || alu_ena !== 1'b0 || alu_instr !== 8'b00_100_011)
      $display("FAIL wait_state: busy/ena/instr %b/%b/%h expected 1/0/23", busy, alu_ena, alu_instr);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || alu_instr !== 8'h00 || alu_ena !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_result !== 6'd0 || rsp_err !== 1'b0 || op_count !== '0 || err_count !== '0)
      $display("FAIL reset_mid_op: ready/instr/valid/busy/ops %b/%h/%b/%b/%0d expected all 0", req_ready, alu_instr, rsp_valid, busy, op_count);
    else n_pass++;
    rst = 1'b0;
    exp_ops = 0; exp_errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL abandoned_op cycle %0d: valid/ready %b/%b expected 0/1", i, rsp_valid, req_ready);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 5; i++) do_op(3, i % 8, 0, 1'b0, 0, 1'b0);
    do_op(0, 2, 3, 1'b0, 0, 1'b1);
    n_checks++;
    if (op_count !== CNT_W'(CNT_MAX) || err_count !== CNT_W'(CNT_MAX))
      $display("FAIL saturation: op/err got %0d/%0d expected %0d/%0d", op_count, err_count, CNT_MAX, CNT_MAX);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_div_by_zero();
    test_mismatch_hold();
    test_random();
    test_reset_mid_op();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
